icache_assoc: RTL and testbench
===============================

# icache_assoc

Parametrised set-associative instruction cache for the instruction-fetch unit; the successor to the direct-mapped fetch cache. It sits between the fetch address generator and the memory controller's line-read port. It returns hits combinationally, runs a refill state machine on a miss, and selects a victim by invalid-first then per-set round-robin. It adds a whole-cache flush for fence.i and branch-mispredict recovery.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, instruction word width in bits
- LINE_WORDS, 4, words per line (power of two, at least 1)
- SETS, 64, number of sets (power of two)
- WAYS, 2, associativity (power of two, at least 1)
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- flush  in  1  invalidate all lines
- rd_ena  in  1  fetch lookup request
- rd_addr  in  ADDR_W  byte address of the fetch; the low 2 bits are ignored
- hit  out  1  lookup hit (combinational)
- hit_data  out  DATA_W  word selected by rd_addr (combinational; valid only when hit=1)
- busy  out  1  refill in progress
- mem_rd_ena  out  1  line-read request (registered, level)
- mem_rd_addr  out  ADDR_W  line-aligned refill address (registered)
- mem_rd_done  in  1  single-cycle pulse: the line is on mem_rd_data
- mem_rd_data  in  LINE_WORDS*DATA_W  line contents; word 0 is in the LSBs

## Operation
- Address split: offset = rd_addr[2 +: log2(LINE_WORDS)], index = next log2(SETS) bits, tag = the remaining upper bits.
- Storage per set per way: a valid bit, a tag and line data. Each set also has a log2(WAYS)-bit round-robin pointer.
- Lookup: hit = rd_ena & !rst & (state==IDLE) & OR over ways of (valid & tag match). hit_data comes from the matching way, word = offset.
- States are IDLE and REFILL.
- IDLE to REFILL: rd_ena=1 and no hit. On that edge:
  - latch index and tag;
  - set mem_rd_addr = rd_addr with the offset and low 2 bits zeroed;
  - set mem_rd_ena=1.
- In REFILL, mem_rd_ena stays high until mem_rd_done.
- On mem_rd_done in REFILL:
  - write the line, tag and valid=1 into the victim way of the latched set, unless the drop flag is set;
  - set mem_rd_ena=0 and return to IDLE.
- Victim selection: the lowest-index invalid way in the set. If all ways are valid, use the set's pointer. The pointer advances by 1 (mod WAYS) on every install into that set.
- The refill always fills the latched line. Changes to rd_addr or rd_ena during REFILL do not affect it.
- mem_rd_done while in IDLE is ignored.
- Flush in IDLE: all valid bits are cleared at the edge. Pointers are unchanged.
- Flush in REFILL: all valid bits are cleared and the drop flag is set. The refill still completes its handshake, but the line is not installed.
- A miss never starts in the same cycle as a flush.
- Reset: all valid bits = 0, all pointers = 0, drop flag = 0, state = IDLE.
- Reset wins over everything, including mid-refill. Any outstanding memory response is ignored afterwards.
- WAYS=1 degenerates to direct-mapped with no pointer logic.

## Timing
- Output values during and after reset: hit=0, busy=0, mem_rd_ena=0, mem_rd_addr=0. hit_data is don't-care while hit=0.
- Hit latency is 0 cycles, same cycle as rd_ena.
- Miss sequence: rd_ena misses in cycle N, then mem_rd_ena=1 and busy=1 from cycle N+1.
- Fill: mem_rd_done arrives in cycle M, the line is written at the end of M, and mem_rd_ena=0 and busy=0 from M+1.
- If the same rd_addr is held, hit=1 at M+1. The minimum miss penalty with M=N+1 is 2 cycles.
- mem_rd_addr is stable for the whole time mem_rd_ena is high.
- hit=0 throughout REFILL; no hit-under-miss.

## Test plan
- Cold miss, default parameters: rd_addr=0x0000_1004 after reset.
  - Required: hit=0, then mem_rd_ena=1 with mem_rd_addr=0x0000_1000 the next cycle.
  - Drive mem_rd_done with data {0xD3,0xD2,0xD1,0xD0}; the next cycle requires hit=1 and hit_data=0xD1.
  - Then rd_addr=0x0000_100C requires hit=1 and hit_data=0xD3 with no memory request.
- Conflict and replacement in set 0:
  - fill 0x1000 into way0, then 0x2000 into way1 (invalid-first);
  - fill 0x3000: it evicts way0 (pointer 0 advances to 1), so 0x2000 still hits and 0x1000 misses;
  - the 0x1000 refill evicts way1, so 0x2000 now misses.
- Flush in IDLE: after caching 0x1000, pulse flush. The next lookup of 0x1000 requires hit=0 and a new mem_rd_ena.
- Flush mid-refill: a miss on 0x4000, then flush while mem_rd_ena=1, then mem_rd_done.
  - Required: mem_rd_ena drops and busy=0.
  - A lookup of 0x4000 misses again.
- Reset mid-refill: assert rst while mem_rd_ena=1.
  - Required next cycle: mem_rd_ena=0, busy=0, hit=0.
  - A stray mem_rd_done afterwards installs nothing; a lookup of the refilled address still misses.
- Parameter sweep: WAYS=1 and SETS=256 with the cold-miss and conflict scenarios.
  - 0x1000 and 0x2000 map to the same set and evict each other alternately.

Source files
------------

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hit path, single-line refill FSM,
// invalid-first / per-set round-robin victim choice, whole-cache flush.
module icache_assoc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         rd_ena,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data,
    output logic                         busy,
    output logic                         mem_rd_ena,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    input  logic                         mem_rd_done,
    input  logic [LINE_WORDS*DATA_W-1:0] mem_rd_data
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int OW    = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W = $clog2(SETS);
    localparam int IW    = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int PW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    logic [0:0]       state;
    logic             drop;
    logic [OW-1:0]    off;
    logic [IW-1:0]    idx;
    logic [TAG_W-1:0] tag;
    logic [IW-1:0]    miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             hit_any;
    logic [PW-1:0]    victim;
    logic             found;
    logic             install;
    logic             unused_low;

    logic [WAYS-1:0]                  valid [SETS];
    logic [PW-1:0]                    ptr   [SETS];
    logic [TAG_W-1:0]                 tags  [SETS][WAYS];
    logic [LINE_WORDS-1:0][DATA_W-1:0] lines [SETS][WAYS];

    generate
        if (OFF_W > 0) begin : g_off
            assign off = rd_addr[2 +: OFF_W];
        end else begin : g_no_off
            assign off = '0;
        end
        if (IDX_W > 0) begin : g_idx
            assign idx = rd_addr[2+OFF_W +: IDX_W];
        end else begin : g_no_idx
            assign idx = '0;
        end
    endgenerate

    assign tag        = rd_addr[ADDR_W-1 -: TAG_W];
    assign unused_low = ^rd_addr[1:0];

    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tags[idx][w] == tag) begin
                hit_any  = 1'b1;
                hit_data = lines[idx][w][off];
            end
        end
    end

    assign hit  = rd_ena & ~rst & (state == IDLE) & hit_any;
    assign busy = (state == REFILL);

    // Lowest invalid way wins; the round-robin pointer only matters for a full set.
    always_comb begin
        victim = ptr[miss_idx];
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[miss_idx][w]) begin
                victim = PW'(w);
                found  = 1'b1;
            end
        end
    end

    // A flush landing on the completion cycle also suppresses the install.
    assign install = (state == REFILL) && mem_rd_done && !drop && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            drop        <= 1'b0;
            mem_rd_ena  <= 1'b0;
            mem_rd_addr <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                ptr[s]   <= '0;
            end
        end else begin
            if (flush) begin
                for (int s = 0; s < SETS; s++) valid[s] <= '0;
            end
            case (state)
                IDLE: begin
                    if (rd_ena && !hit_any && !flush) begin
                        state       <= REFILL;
                        mem_rd_ena  <= 1'b1;
                        mem_rd_addr <= {rd_addr[ADDR_W-1:2+OFF_W], {(2+OFF_W){1'b0}}};
                    end
                end
                default: begin
                    if (flush) drop <= 1'b1;
                    if (mem_rd_done) begin
                        state      <= IDLE;
                        mem_rd_ena <= 1'b0;
                        drop       <= 1'b0;
                    end
                    if (install) begin
                        valid[miss_idx][victim] <= 1'b1;
                        if (WAYS > 1) ptr[miss_idx] <= ptr[miss_idx] + PW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && rd_ena && !hit_any) begin
            miss_idx <= idx;
            miss_tag <= tag;
        end
        if (install && !rst) begin
            tags[miss_idx][victim]  <= miss_tag;
            lines[miss_idx][victim] <= mem_rd_data;
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: a 2-way/64-set instance and a direct-mapped/256-set instance,
// driven from a lookup table plus hand-written flush/reset-during-refill sequences.
module tb_icache_assoc;
    logic         clk = 1'b0;
    logic         rst         [2];
    logic         flush       [2];
    logic         rd_ena      [2];
    logic [31:0]  rd_addr     [2];
    logic         hit         [2];
    logic [31:0]  hit_data    [2];
    logic         busy        [2];
    logic         mem_rd_ena  [2];
    logic [31:0]  mem_rd_addr [2];
    logic         mem_rd_done [2];
    logic [127:0] mem_rd_data [2];

    always #5 clk = ~clk;

    icache_assoc #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(64), .WAYS(2)) dut0 (
        .clk(clk), .rst(rst[0]), .flush(flush[0]), .rd_ena(rd_ena[0]), .rd_addr(rd_addr[0]),
        .hit(hit[0]), .hit_data(hit_data[0]), .busy(busy[0]), .mem_rd_ena(mem_rd_ena[0]),
        .mem_rd_addr(mem_rd_addr[0]), .mem_rd_done(mem_rd_done[0]), .mem_rd_data(mem_rd_data[0]));

    icache_assoc #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(256), .WAYS(1)) dut1 (
        .clk(clk), .rst(rst[1]), .flush(flush[1]), .rd_ena(rd_ena[1]), .rd_addr(rd_addr[1]),
        .hit(hit[1]), .hit_data(hit_data[1]), .busy(busy[1]), .mem_rd_ena(mem_rd_ena[1]),
        .mem_rd_addr(mem_rd_addr[1]), .mem_rd_done(mem_rd_done[1]), .mem_rd_data(mem_rd_data[1]));

    typedef struct {
        string       name;
        int          s;
        logic        hit;
        logic        chk_data;
        logic [31:0] data;
        logic        ena;
        logic        busy;
        logic        chk_addr;
        logic [31:0] addr;
    } exp_t;

    typedef struct {
        int          s;
        int          op;
        logic [31:0] addr;
        logic        exp_hit;
    } vec_t;

    localparam int OP_LOOK  = 0;
    localparam int OP_FLUSH = 1;

    exp_t sb[$];
    vec_t vt[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Memory image: line 0x1000 holds D0..D3, other lines are offset so every word is distinct.
    function automatic logic [31:0] word_of(logic [31:0] a);
        logic [31:0] l;
        l = a & ~32'hF;
        return (((l >> 4) - 32'h100) << 8) | (32'hD0 + {30'd0, a[3:2]});
    endfunction

    function automatic logic [127:0] line_of(logic [31:0] a);
        logic [127:0] ln;
        for (int i = 0; i < 4; i++) ln[i*32 +: 32] = word_of((a & ~32'hF) | (i << 2));
        return ln;
    endfunction

    task automatic cmp(string n, logic [31:0] act, logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", n, act, req);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        e = sb.pop_front();
        cmp({e.name, " hit"}, {31'd0, hit[e.s]}, {31'd0, e.hit});
        cmp({e.name, " busy"}, {31'd0, busy[e.s]}, {31'd0, e.busy});
        cmp({e.name, " mem_rd_ena"}, {31'd0, mem_rd_ena[e.s]}, {31'd0, e.ena});
        if (e.chk_data) cmp({e.name, " hit_data"}, hit_data[e.s], e.data);
        if (e.chk_addr) cmp({e.name, " mem_rd_addr"}, mem_rd_addr[e.s], e.addr);
    endtask

    task automatic expect_now(string n, int s, logic h, logic cd, logic [31:0] d,
                              logic en, logic b, logic ca, logic [31:0] a);
        exp_t e;
        e = '{name: n, s: s, hit: h, chk_data: cd, data: d, ena: en, busy: b, chk_addr: ca, addr: a};
        sb.push_back(e);
        check_pop();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a missing lookup was presented; the miss is taken at the next edge.
    task automatic refill(int s, logic [31:0] a, string nm);
        step();
        rd_addr[s] = a ^ 32'h0000_7000;
        #1;
        expect_now({nm, " req"}, s, 0, 0, '0, 1, 1, 1, a & ~32'hF);
        step();
        rd_addr[s]     = a;
        mem_rd_done[s] = 1'b1;
        mem_rd_data[s] = line_of(a);
        #1;
        expect_now({nm, " req held"}, s, 0, 0, '0, 1, 1, 1, a & ~32'hF);
        step();
        mem_rd_done[s] = 1'b0;
        mem_rd_data[s] = '0;
        #1;
        expect_now({nm, " filled"}, s, 1, 1, word_of(a), 0, 0, 0, '0);
    endtask

    task automatic do_lookup(int s, logic [31:0] a, logic exp_hit, string nm);
        step();
        rd_ena[s]      = 1'b1;
        rd_addr[s]     = a;
        flush[s]       = 1'b0;
        mem_rd_done[s] = 1'b0;
        #1;
        if (exp_hit) begin
            expect_now({nm, " lookup"}, s, 1, 1, word_of(a), 0, 0, 0, '0);
            step();
            expect_now({nm, " no request"}, s, 1, 0, '0, 0, 0, 0, '0);
            rd_ena[s] = 1'b0;
        end else begin
            expect_now({nm, " lookup"}, s, 0, 0, '0, 0, 0, 0, '0);
            refill(s, a, nm);
        end
    endtask

    task automatic do_flush(int s);
        step();
        rd_ena[s] = 1'b0;
        flush[s]  = 1'b1;
        step();
        flush[s] = 1'b0;
    endtask

    function automatic void add(int s, int op, logic [31:0] a, logic h);
        vec_t v;
        v = '{s: s, op: op, addr: a, exp_hit: h};
        vt.push_back(v);
    endfunction

    initial begin
        // 2-way: cold miss, then set-0 conflicts exercising invalid-first and round-robin.
        add(0, OP_LOOK, 32'h1004, 0); add(0, OP_LOOK, 32'h100C, 1);
        add(0, OP_LOOK, 32'h2000, 0); add(0, OP_LOOK, 32'h1008, 1);
        add(0, OP_LOOK, 32'h2004, 1); add(0, OP_LOOK, 32'h3000, 0);
        add(0, OP_LOOK, 32'h2000, 1); add(0, OP_LOOK, 32'h1000, 0);
        add(0, OP_LOOK, 32'h3000, 1); add(0, OP_LOOK, 32'h2000, 0);
        add(0, OP_LOOK, 32'h1000, 1); add(0, OP_LOOK, 32'h3000, 0);
        add(0, OP_LOOK, 32'h1010, 0); add(0, OP_LOOK, 32'h1018, 1);
        add(0, OP_LOOK, 32'h3004, 1); add(0, OP_FLUSH, 32'h0, 0);
        add(0, OP_LOOK, 32'h1010, 0); add(0, OP_LOOK, 32'h2000, 0);
        // Direct-mapped, 256 sets: 0x1000 and 0x2000 share set 0.
        add(1, OP_LOOK, 32'h1004, 0); add(1, OP_LOOK, 32'h100C, 1);
        add(1, OP_LOOK, 32'h2000, 0); add(1, OP_LOOK, 32'h1000, 0);
        add(1, OP_LOOK, 32'h2008, 0); add(1, OP_LOOK, 32'h2000, 1);
        add(1, OP_LOOK, 32'h1100, 0); add(1, OP_LOOK, 32'h2004, 1);

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; flush[s] = 1'b0; rd_ena[s] = 1'b1; rd_addr[s] = 32'h1004;
            mem_rd_done[s] = 1'b0; mem_rd_data[s] = '0;
        end
        step();
        step();
        expect_now("reset dut0", 0, 0, 0, '0, 0, 0, 1, '0);
        expect_now("reset dut1", 1, 0, 0, '0, 0, 0, 1, '0);
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b0; rd_ena[s] = 1'b0;
        end

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].op == OP_FLUSH) do_flush(vt[i].s);
            else do_lookup(vt[i].s, vt[i].addr, vt[i].exp_hit,
                           $sformatf("vec%0d @%h", i, vt[i].addr));
        end

        // Flush while the refill of 0x4000 is outstanding: the line must be dropped.
        step();
        rd_ena[0] = 1'b1; rd_addr[0] = 32'h4000;
        #1;
        expect_now("fmid lookup", 0, 0, 0, '0, 0, 0, 0, '0);
        step();
        expect_now("fmid req", 0, 0, 0, '0, 1, 1, 1, 32'h4000);
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        expect_now("fmid after flush", 0, 0, 0, '0, 1, 1, 1, 32'h4000);
        mem_rd_done[0] = 1'b1; mem_rd_data[0] = line_of(32'h4000);
        step();
        mem_rd_done[0] = 1'b0;
        expect_now("fmid dropped", 0, 0, 0, '0, 0, 0, 0, '0);
        refill(0, 32'h4000, "fmid refetch");

        // Reset mid-refill; the late response must not install anything.
        step();
        rd_ena[0] = 1'b1; rd_addr[0] = 32'h5000;
        #1;
        expect_now("rmid lookup", 0, 0, 0, '0, 0, 0, 0, '0);
        step();
        expect_now("rmid req", 0, 0, 0, '0, 1, 1, 1, 32'h5000);
        rst[0] = 1'b1; rd_addr[0] = 32'h4000;
        step();
        expect_now("rmid in reset", 0, 0, 0, '0, 0, 0, 1, '0);
        rst[0] = 1'b0; rd_ena[0] = 1'b0;
        mem_rd_done[0] = 1'b1; mem_rd_data[0] = line_of(32'h5000);
        step();
        mem_rd_done[0] = 1'b0;
        expect_now("rmid stray done", 0, 0, 0, '0, 0, 0, 1, '0);
        do_lookup(0, 32'h5000, 0, "rmid refetch");
        do_lookup(0, 32'h4000, 0, "rmid cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
